// File: rtl/produce_spawn_scheduler.sv
// Spawn scheduler: turns the LFSR byte into paced, fairness-filtered spawn
// requests (type, lane, gap) and offers each one over a valid/ready handshake.
module produce_spawn_scheduler #(
  parameter logic [7:0] MIN_GAP = 8'd30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tick,
  input  logic [7:0] rnd,
  input  logic       spawn_ready,
  output logic       spawn_valid,
  output logic [1:0] spawn_type,
  output logic [2:0] spawn_lane,
  output logic [7:0] spawn_gap,
  output logic [7:0] spawn_count
);

  typedef enum logic [1:0] {IDLE, GAP, DRAW, OFFER} state_t;

  state_t     state;
  logic [7:0] gap_cnt;
  logic       prev_valid;
  logic       prev_bomb;
  logic [2:0] prev_lane;

  logic [1:0] draw_type;
  logic [2:0] draw_lane;
  logic [7:0] draw_gap;

  // Fairness filter on the raw byte: no bomb after a bomb, no repeated lane.
  always_comb begin
    draw_type = rnd[7:6];
    if (draw_type == 2'd3 && prev_bomb)
      draw_type = 2'd0;
    draw_lane = rnd[2:0];
    if (prev_valid && draw_lane == prev_lane)
      draw_lane = draw_lane + 3'd1;
    draw_gap = MIN_GAP + {5'd0, rnd[5:3]};
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // branch below reads the pre-edge values of all registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gap_cnt     <= 8'd0;
      prev_valid  <= 1'b0;
      prev_bomb   <= 1'b0;
      prev_lane   <= 3'd0;
      spawn_valid <= 1'b0;
      spawn_type  <= 2'd0;
      spawn_lane  <= 3'd0;
      spawn_gap   <= 8'd0;
      spawn_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= GAP;
            gap_cnt <= MIN_GAP;
          end
        end
        GAP: begin
          if (!enable)
            state <= IDLE;
          else if (gap_cnt == 8'd0)
            state <= DRAW;
          else if (tick)
            gap_cnt <= gap_cnt - 8'd1;
        end
        DRAW: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            spawn_type  <= draw_type;
            spawn_lane  <= draw_lane;
            spawn_gap   <= draw_gap;
            spawn_valid <= 1'b1;
            state       <= OFFER;
          end
        end
        OFFER: begin
          // Offer is never withdrawn; enable only decides where we go after it.
          if (spawn_ready) begin
            spawn_valid <= 1'b0;
            prev_valid  <= 1'b1;
            prev_bomb   <= (spawn_type == 2'd3);
            prev_lane   <= spawn_lane;
            if (spawn_count != 8'hFF)
              spawn_count <= spawn_count + 8'd1;
            if (enable) begin
              state   <= GAP;
              gap_cnt <= spawn_gap;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_produce_spawn_scheduler.sv
// Directed bench for produce_spawn_scheduler: expected spawns are queued when
// stimulus is set up and compared when the DUT offers them.
module tb_produce_spawn_scheduler;

  typedef struct packed {
    logic [1:0] t;
    logic [2:0] l;
    logic [7:0] g;
  } spawn_t;

  localparam logic [7:0] GAP_A = 8'd2;
  localparam logic [7:0] GAP_B = 8'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, tick, spawn_ready;
  logic [7:0] rnd;
  logic       spawn_valid;
  logic [1:0] spawn_type;
  logic [2:0] spawn_lane;
  logic [7:0] spawn_gap, spawn_count;

  logic       en3, tick3, ready3;
  logic [7:0] rnd3;
  logic       v3;
  logic [1:0] t3;
  logic [2:0] l3;
  logic [7:0] g3, c3;

  int compared   = 0;
  int mismatched = 0;

  spawn_t     sb[$];
  logic       m_prev_valid, m_prev_bomb;
  logic [2:0] m_prev_lane;
  int         m_count;

  always #5 clk = ~clk;

  produce_spawn_scheduler #(.MIN_GAP(GAP_A)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .tick(tick), .rnd(rnd),
    .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_type(spawn_type),
    .spawn_lane(spawn_lane), .spawn_gap(spawn_gap), .spawn_count(spawn_count)
  );

  produce_spawn_scheduler #(.MIN_GAP(GAP_B)) u_dut3 (
    .clk(clk), .rst(rst), .enable(en3), .tick(tick3), .rnd(rnd3),
    .spawn_ready(ready3), .spawn_valid(v3), .spawn_type(t3),
    .spawn_lane(l3), .spawn_gap(g3), .spawn_count(c3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_prev_valid = 1'b0;
    m_prev_bomb  = 1'b0;
    m_prev_lane  = 3'd0;
    m_count      = 0;
  endtask

  // Queue an expected spawn and record it as history (it will be accepted).
  task automatic push_exp(input spawn_t s);
    sb.push_back(s);
    m_prev_valid = 1'b1;
    m_prev_bomb  = (s.t == 2'd3);
    m_prev_lane  = s.l;
  endtask

  function automatic spawn_t model_draw(input logic [7:0] r);
    spawn_t s;
    s.t = r[7:6];
    if (s.t == 2'd3 && m_prev_bomb) s.t = 2'd0;
    s.l = r[2:0];
    if (m_prev_valid && s.l == m_prev_lane) s.l = s.l + 3'd1;
    s.g = GAP_A + {5'd0, r[5:3]};
    return s;
  endfunction

  // Called on a falling edge; waits (bounded) for an offer and compares it.
  task automatic expect_spawn(input string tag);
    spawn_t e;
    int waited = 0;
    while (!spawn_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s scoreboard empty observed=offer expected=none", tag);
      return;
    end
    e = sb.pop_front();
    if (!spawn_valid) begin
      compared++;
      mismatched++;
      $error("FAIL %s timeout observed=no_offer expected=offer", tag);
      return;
    end
    check({tag, ".type"}, 32'(spawn_type), 32'(e.t));
    check({tag, ".lane"}, 32'(spawn_lane), 32'(e.l));
    check({tag, ".gap"},  32'(spawn_gap),  32'(e.g));
  endtask

  // Raise ready at the detection edge; handshake completes on the next edge.
  task automatic accept(input string tag);
    spawn_ready = 1'b1;
    @(negedge clk);
    if (m_count < 255) m_count++;
    check({tag, ".valid_drop"}, 32'(spawn_valid), 32'd0);
    check({tag, ".count"}, 32'(spawn_count), 32'(m_count));
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (spawn_valid) seen = 1'b1;
    end
    check({tag, ".no_spawn"}, 32'(seen), 32'd0);
    check({tag, ".count"}, 32'(spawn_count), 32'(m_count));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    spawn_t snap_s;
    logic [7:0] snap_c;
    int first;
    logic seen3;
    logic [7:0] r;

    rst = 1'b0; enable = 1'b1; tick = 1'b1; rnd = 8'hD5; spawn_ready = 1'b1;
    en3 = 1'b0; tick3 = 1'b0; rnd3 = 8'h40; ready3 = 1'b1;
    model_clear();
    repeat (4) @(negedge clk);
    check("rst.valid", 32'(spawn_valid), 32'd0);
    check("rst.type",  32'(spawn_type),  32'd0);
    check("rst.lane",  32'(spawn_lane),  32'd0);
    check("rst.gap",   32'(spawn_gap),   32'd0);
    check("rst.count", 32'(spawn_count), 32'd0);
    check("rst.valid3", 32'(v3), 32'd0);

    // Tick gating on the MIN_GAP=3 instance while the main one is held idle.
    enable = 1'b0;
    rst = 1'b1;
    first = -1;
    en3 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick3 = (k % 4 == 3);
      @(negedge clk);
      if (v3 && first < 0) begin
        first = k + 1;
        snap_s = '{t: t3, l: l3, g: g3};
      end
    end
    check("tick.first_offer", 32'(first), 32'd14);
    check("tick.fields", 32'(snap_s), 32'({2'd1, 3'd0, 8'd3}));
    tick3 = 1'b0;
    seen3 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (v3) seen3 = 1'b1;
    end
    check("tick.no_spawn_tick0", 32'(seen3), 32'd0);
    check("tick.count3", 32'(c3), 32'd1);
    en3 = 1'b0;

    // First draw and bomb suppression with rnd held at D5.
    enable = 1'b1;
    push_exp('{t: 2'd3, l: 3'd5, g: 8'd4});
    expect_spawn("first");
    accept("first");
    push_exp('{t: 2'd0, l: 3'd6, g: 8'd4});
    expect_spawn("second");
    accept("second");

    // Lane wrap 7 -> 0.
    rnd = 8'h47;
    push_exp('{t: 2'd1, l: 3'd7, g: 8'd2});
    expect_spawn("lane7");
    rnd = 8'h07;
    accept("lane7");
    push_exp('{t: 2'd0, l: 3'd0, g: 8'd2});
    expect_spawn("wrap");
    accept("wrap");

    // Backpressure: ten stalled cycles, then exactly one acceptance.
    spawn_ready = 1'b0;
    rnd = 8'h9A;
    push_exp('{t: 2'd2, l: 3'd2, g: 8'd5});
    expect_spawn("bp");
    snap_s = '{t: spawn_type, l: spawn_lane, g: spawn_gap};
    snap_c = spawn_count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp.valid_held", 32'(spawn_valid), 32'd1);
      check("bp.fields_held", 32'({spawn_type, spawn_lane, spawn_gap, spawn_count}),
            32'({snap_s, snap_c}));
    end
    rnd = 8'hD5;
    accept("bp");
    spawn_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("bp.exactly_one", 32'(spawn_count), 32'(m_count));
    push_exp('{t: 2'd3, l: 3'd5, g: 8'd4});
    expect_spawn("bp_next");
    accept("bp_next");

    // Enable dropped in GAP: back to IDLE, no spawn.
    tick = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    watch_idle("en_gap", 20);
    enable = 1'b1;
    push_exp(model_draw(rnd));
    expect_spawn("en_gap_resume");
    rnd = 8'h23;
    accept("en_gap_resume");

    // Enable dropped in OFFER: offer held, accepted, then IDLE.
    spawn_ready = 1'b0;
    push_exp(model_draw(rnd));
    expect_spawn("en_offer");
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("en_offer.valid_held", 32'(spawn_valid), 32'd1);
    accept("en_offer");
    watch_idle("en_offer_idle", 20);

    // Build bomb/lane history, then reset in the middle of an offer.
    enable = 1'b1;
    rnd = 8'hD5;
    push_exp(model_draw(rnd));
    expect_spawn("pre_rst");
    accept("pre_rst");
    spawn_ready = 1'b0;
    push_exp(model_draw(rnd));
    expect_spawn("rst_offer");
    #2 rst = 1'b0;
    #1;
    check("rst_mid.valid", 32'(spawn_valid), 32'd0);
    check("rst_mid.count", 32'(spawn_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    spawn_ready = 1'b1;
    push_exp('{t: 2'd3, l: 3'd5, g: 8'd4});
    expect_spawn("post_rst");
    r = 8'($urandom);
    rnd = r;
    accept("post_rst");

    // Long run to saturate the counter.
    for (int n = 1; n < 300; n++) begin
      push_exp(model_draw(rnd));
      expect_spawn("sat");
      r = 8'($urandom);
      rnd = r;
      accept("sat");
    end
    check("sat.final_count", 32'(spawn_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/produce_spawn_scheduler.md
# produce_spawn_scheduler

Downstream consumer of the 8-bit `lfsr` pseudo-random stream. Turns the random byte into timed spawn requests for the game logic. Each request carries a produce type, a lane and the gap to the next spawn. It paces spawns on the frame tick, enforces fairness rules (no back-to-back bombs, no repeated lane), and hands each request off over a valid/ready handshake.

## Interface
- `MIN_GAP`, 8'd30, minimum frame ticks between spawns. Legal range 0..248.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous reset, active-low (0 = reset).
- `enable`  in  1  spawning allowed (game running).
- `tick`  in  1  one-cycle pulse per video frame.
- `rnd`  in  8  random byte, driven directly from `lfsr` `q`.
- `spawn_ready`  in  1  game logic accepts the offered spawn.
- `spawn_valid`  out  1  spawn request offered.
- `spawn_type`  out  2  0/1/2 = produce kinds, 3 = bomb.
- `spawn_lane`  out  3  horizontal lane 0..7.
- `spawn_gap`  out  8  ticks that will elapse before the next draw.
- `spawn_count`  out  8  accepted spawns since reset, saturating.

## Operation
- States:
  - IDLE: waiting for `enable`.
  - GAP: counting down frame ticks.
  - DRAW: single cycle; samples `rnd`.
  - OFFER: `spawn_valid`=1 until the request is accepted.
- IDLE -> GAP when `enable`=1; gap counter loads `MIN_GAP`.
- GAP:
  - if `enable`=0 -> IDLE;
  - else if counter==0 -> DRAW;
  - else decrement on cycles with `tick`=1.
- DRAW (`enable`=0 -> IDLE, nothing latched; else -> OFFER). Latch from the current `rnd`:
  - type = `rnd[7:6]`. If type==3 and the previous accepted spawn was a bomb, type = 0.
  - lane = `rnd[2:0]`. If a previous accepted spawn exists and the lane equals its lane, lane = (lane+1) mod 8, so 7 wraps to 0.
  - gap = `MIN_GAP` + `rnd[5:3]`, 8-bit, no overflow within the legal `MIN_GAP` range.
- OFFER: outputs stay stable while `spawn_valid`=1 and `spawn_ready`=0.
  - On `spawn_valid`&&`spawn_ready`: update prev_bomb/prev_lane/prev_valid and increment `spawn_count` (holds at 255).
  - Then go to GAP with counter = latched gap if `enable`=1, else to IDLE.
  - `enable` falling during OFFER does not withdraw the offer.
- `tick` is ignored outside GAP. `rnd` is ignored outside DRAW.
- `spawn_gap` is the gap actually loaded after acceptance.

## Timing
- Reset (`rst`=0, asynchronous), all values 0:
  - state IDLE;
  - `spawn_valid`, `spawn_type`, `spawn_lane`, `spawn_gap`, `spawn_count`;
  - prev_valid, prev_bomb, prev_lane, gap counter.
- Reset release mid-operation: restart from IDLE. History is cleared, so the first spawn after reset has no bomb or lane restriction.
- `enable` high at edge N: GAP from N+1. With `MIN_GAP`=0, DRAW at N+2 and `spawn_valid` at N+3.
- Counter==k in GAP needs k tick pulses. DRAW follows in the cycle after the counter reaches 0.
- `rnd` is sampled at the DRAW edge. `spawn_*` outputs are registered and valid from the next cycle.
- Handshake completes on the edge where `spawn_valid`=`spawn_ready`=1.
  - `spawn_valid` drops the following cycle.
  - Minimum spacing between accepted spawns, with `tick` held high: gap+3 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset, first draw and bomb suppression. `MIN_GAP`=2, `tick`=1, `spawn_ready`=1, `rnd`=8'hD5 held.
  - Required: all outputs 0 during reset.
  - First spawn: type 3, lane 5, gap 4 (2+2).
  - Second spawn: type 0 (bomb suppressed), lane 6 (repeat bumped).
  - `spawn_count` = 1, then 2.
- Lane wrap: accepted lane 7, then `rnd`=8'h07 -> lane 0, type 0, gap `MIN_GAP`.
- Backpressure: `spawn_ready`=0 for 10 cycles during OFFER.
  - `spawn_valid` and all fields stay constant; `spawn_count` unchanged.
  - Raising `spawn_ready` accepts exactly one spawn.
- Tick gating: `MIN_GAP`=3, `tick` pulsed every 4th cycle -> DRAW only after 3 pulses; no spawn with `tick`=0.
- Enable control:
  - `enable` dropped in GAP -> IDLE, no spawn.
  - `enable` dropped in OFFER -> offer held, accepted, then IDLE.
- Reset mid-OFFER: `spawn_valid` goes 0 immediately (asynchronous). The next spawn ignores the earlier bomb/lane history; `spawn_count` restarts from 0. Run 300 spawns and check `spawn_count` saturates at 255.
